// File: rtl/pkt_dmem_loader.sv
// pkt_dmem_loader
// Forwards every packet word through one register stage. Packets whose EtherType
// matches ETHERTYPE are also written into the CPU data memory write port, one
// 64-bit payload word per address starting at load_base. Writes happen only
// while the CPU is halted (cpu_en=0).
// Build option: define LOADER_STATS_EN to build the pkt_count / load_pkt_count
// statistics counters. When it is undefined, both outputs are tied to zero.
module pkt_dmem_loader #(
    parameter int          DATA_WIDTH = 64,
    parameter int          CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  load_en,
    input  logic                  cpu_en,
    input  logic [ADDR_WIDTH-1:0] load_base,
    output logic                  load_we,
    output logic [ADDR_WIDTH-1:0] load_addr,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_done,
    output logic                  load_ovf,
    output logic [8:0]            load_words,
    output logic [31:0]           pkt_count,
    output logic [31:0]           load_pkt_count
);

    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_W1   = 3'd2,
        S_LOAD = 3'd3,
        S_PASS = 3'd4
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] base_r;   // load_base captured on entry to S_LOAD
    logic [8:0]            idx_r;    // payload word index n, stops at MAX_WORDS
    logic                  susp_r;   // CPU came up during this load: no more writes

    logic accept_s;
    logic eop_s;
    logic hdr_s;
    logic match_s;
    logic in_range_s;
    logic body0_s;
    logic load_start_s;

    assign in_rdy       = out_rdy;
    assign accept_s     = in_wr & out_rdy;
    assign eop_s        = (in_ctrl != {CTRL_WIDTH{1'b0}});
    assign hdr_s        = (in_ctrl == {CTRL_WIDTH{1'b1}});
    assign match_s      = (in_data[31:16] == ETHERTYPE);
    assign in_range_s   = (idx_r < MAX_W);
    assign body0_s      = accept_s & (state_r == S_HDR) & ~eop_s;
    assign load_start_s = accept_s & (state_r == S_W1) & ~eop_s & match_s & load_en & ~cpu_en;

    // Forward path: one register stage carrying every accepted word unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr   <= 1'b0;
            out_data <= {DATA_WIDTH{1'b0}};
            out_ctrl <= {CTRL_WIDTH{1'b0}};
        end else begin
            out_wr <= accept_s;
            if (accept_s) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end
        end
    end

    // Packet classifier and dmem write port; outputs line up with the forwarded word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            base_r     <= {ADDR_WIDTH{1'b0}};
            idx_r      <= 9'd0;
            susp_r     <= 1'b0;
            load_we    <= 1'b0;
            load_addr  <= {ADDR_WIDTH{1'b0}};
            load_data  <= {DATA_WIDTH{1'b0}};
            load_done  <= 1'b0;
            load_ovf   <= 1'b0;
            load_words <= 9'd0;
        end else begin
            load_we   <= 1'b0;
            load_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Only a module header starts classification, so a packet
                    // cut by reset is forwarded without being looked at.
                    if (accept_s && hdr_s) begin
                        state_r <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (body0_s) begin
                        state_r <= S_W1;
                    end
                end
                S_W1: begin
                    if (accept_s) begin
                        if (eop_s) begin
                            state_r <= S_IDLE;
                        end else if (load_start_s) begin
                            state_r    <= S_LOAD;
                            base_r     <= load_base;
                            idx_r      <= 9'd0;
                            susp_r     <= 1'b0;
                            load_words <= 9'd0;
                            load_ovf   <= 1'b0;
                        end else begin
                            state_r <= S_PASS;
                        end
                    end
                end
                S_LOAD: begin
                    if (cpu_en) begin
                        susp_r <= 1'b1;
                    end
                    if (accept_s) begin
                        if (in_range_s) begin
                            idx_r <= idx_r + 9'd1;
                            if (!susp_r && !cpu_en) begin
                                load_we    <= 1'b1;
                                load_addr  <= base_r + ADDR_WIDTH'(idx_r);
                                load_data  <= in_data;
                                load_words <= load_words + 9'd1;
                            end
                        end else begin
                            load_ovf <= 1'b1;
                        end
                        if (eop_s) begin
                            load_done <= 1'b1;
                            state_r   <= S_IDLE;
                        end
                    end
                end
                S_PASS: begin
                    if (accept_s && eop_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_STATS_EN
    logic [31:0] pkt_count_r;
    logic [31:0] load_pkt_count_r;

    // Statistics: packets that reached body word 0, and packets captured as loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_r      <= 32'd0;
            load_pkt_count_r <= 32'd0;
        end else begin
            if (body0_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (load_start_s) begin
                load_pkt_count_r <= load_pkt_count_r + 32'd1;
            end
        end
    end

    assign pkt_count      = pkt_count_r;
    assign load_pkt_count = load_pkt_count_r;
`else
    assign pkt_count      = 32'd0;
    assign load_pkt_count = 32'd0;
`endif

endmodule
